// File: rtl/stream_rr_arbiter_pkg.sv
// Shared types and helpers for the stream round-robin arbiter.
package stream_rr_arbiter_pkg;

  // Packet-lock state; the locked requester index is held alongside it.
  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  // Requester index width; never narrower than one bit so a single
  // requester still has a legal select port.
  function automatic int addr_width_f(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// Handshake bundle between the requesters, the arbiter and the downstream sink.
interface stream_rr_arbiter_if
  import stream_rr_arbiter_pkg::*;
#(
  parameter int WORD_WIDTH  = 8,
  parameter int INPUT_COUNT = 4,
  parameter int ADDR_WIDTH  = addr_width_f(INPUT_COUNT)
);

  logic [INPUT_COUNT-1:0]            in_valid_i;
  logic [INPUT_COUNT-1:0]            in_ready_o;
  logic [WORD_WIDTH*INPUT_COUNT-1:0] in_data_i;
  logic [INPUT_COUNT-1:0]            in_last_i;
  logic                              out_valid_o;
  logic                              out_ready_i;
  logic [WORD_WIDTH-1:0]             out_data_o;
  logic [ADDR_WIDTH-1:0]             out_sel_o;
  logic                              out_last_o;

  // Arbiter side.
  modport slave (
    input  in_valid_i, in_data_i, in_last_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_sel_o, out_last_o
  );

  // Requester / sink side.
  modport master (
    output in_valid_i, in_data_i, in_last_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_sel_o, out_last_o
  );

endinterface

// File: rtl/stream_rr_arbiter_mux.sv
// Word multiplexer: picks one WORD_WIDTH slice out of the packed requester words.
module stream_rr_arbiter_mux #(
  parameter int WORD_WIDTH  = 8,
  parameter int INPUT_COUNT = 4,
  parameter int ADDR_WIDTH  = 2
) (
  input  logic [ADDR_WIDTH-1:0]             sel,
  input  logic [WORD_WIDTH*INPUT_COUNT-1:0] words,
  output logic [WORD_WIDTH-1:0]             word
);

  // Select the word whose index matches sel; out-of-range indices give zero.
  always_comb begin
    word = '0;
    for (int k = 0; k < INPUT_COUNT; k++) begin
      if (sel == ADDR_WIDTH'(k)) word = words[k*WORD_WIDTH +: WORD_WIDTH];
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin stream arbiter with a registered single-word output stage.
// Define STREAM_RR_ARBITER_LOCK_EN to hold the grant for a whole packet
// (until the granted requester presents in_last_i).
//
// Lock FSM (only with STREAM_RR_ARBITER_LOCK_EN):
//   state    | meaning
//   UNLOCKED | every beat arbitrated round-robin from ptr
//   LOCKED   | mid-packet; only lock_idx may be granted, others wait
module stream_rr_arbiter
  import stream_rr_arbiter_pkg::*;
#(
  parameter int WORD_WIDTH  = 8,
  parameter int INPUT_COUNT = 4,
  parameter int ADDR_WIDTH  = addr_width_f(INPUT_COUNT)
) (
  input logic                clk_i,
  input logic                rst_ni,
  stream_rr_arbiter_if.slave bus
);

  logic [ADDR_WIDTH-1:0]  ptr_q;
  logic [ADDR_WIDTH-1:0]  ptr_next;
  logic [ADDR_WIDTH-1:0]  rr_idx;
  logic                   rr_found;
  logic [ADDR_WIDTH-1:0]  grant_idx;
  logic                   grant_vld;
  logic                   grant_last;
  logic [WORD_WIDTH-1:0]  grant_word;
  logic [INPUT_COUNT-1:0] ready;
  logic                   ld;
  logic                   xfer;
  logic                   ptr_adv;

  logic                   out_valid_q;
  logic [WORD_WIDTH-1:0]  out_data_q;
  logic [ADDR_WIDTH-1:0]  out_sel_q;
  logic                   out_last_q;

  assign ld = !out_valid_q || bus.out_ready_i;

  // Round-robin search: first valid at or above ptr, else first valid from 0.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 0; k < INPUT_COUNT; k++) begin
      if (!rr_found && ADDR_WIDTH'(k) >= ptr_q && bus.in_valid_i[k]) begin
        rr_found = 1'b1;
        rr_idx   = ADDR_WIDTH'(k);
      end
    end
    for (int k = 0; k < INPUT_COUNT; k++) begin
      if (!rr_found && bus.in_valid_i[k]) begin
        rr_found = 1'b1;
        rr_idx   = ADDR_WIDTH'(k);
      end
    end
  end

`ifdef STREAM_RR_ARBITER_LOCK_EN
  lock_state_e           state_q, state_next;
  logic [ADDR_WIDTH-1:0] lock_idx_q, lock_idx_next;

  // While locked the grant is pinned to the packet owner, even if it stalls.
  always_comb begin
    grant_idx = rr_idx;
    grant_vld = rr_found;
    if (state_q == LOCKED) begin
      grant_idx = lock_idx_q;
      grant_vld = 1'b0;
      for (int k = 0; k < INPUT_COUNT; k++) begin
        if (lock_idx_q == ADDR_WIDTH'(k)) grant_vld = bus.in_valid_i[k];
      end
    end
  end

  // Fairness pointer only moves once a packet has completed.
  assign ptr_adv = xfer && grant_last;

  // Lock state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= UNLOCKED;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_next;
      lock_idx_q <= lock_idx_next;
    end
  end

  // Lock next-state: enter on a non-last beat, leave on the owner's last beat.
  always_comb begin
    state_next    = state_q;
    lock_idx_next = lock_idx_q;
    case (state_q)
      UNLOCKED: begin
        if (xfer && !grant_last) begin
          state_next    = LOCKED;
          lock_idx_next = grant_idx;
        end
      end
      LOCKED: begin
        if (xfer && grant_last) state_next = UNLOCKED;
      end
      default: state_next = UNLOCKED;
    endcase
  end
`else
  assign grant_idx = rr_idx;
  assign grant_vld = rr_found;
  assign ptr_adv   = xfer;
`endif

  // One-hot accept towards the granted requester; suppressed during reset.
  always_comb begin
    ready      = '0;
    grant_last = 1'b0;
    for (int k = 0; k < INPUT_COUNT; k++) begin
      if (grant_idx == ADDR_WIDTH'(k)) begin
        ready[k]   = rst_ni && ld && grant_vld;
        grant_last = bus.in_last_i[k];
      end
    end
  end

  assign xfer     = |ready;
  assign ptr_next = (grant_idx == ADDR_WIDTH'(INPUT_COUNT - 1)) ? '0
                                                               : grant_idx + ADDR_WIDTH'(1);

  stream_rr_arbiter_mux #(
    .WORD_WIDTH (WORD_WIDTH),
    .INPUT_COUNT(INPUT_COUNT),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mux (
    .sel  (grant_idx),
    .words(bus.in_data_i),
    .word (grant_word)
  );

  // Output register and fairness pointer; data holds after a drain.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_last_q  <= 1'b0;
      ptr_q       <= '0;
    end else begin
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= grant_word;
        out_sel_q   <= grant_idx;
        out_last_q  <= grant_last;
      end else if (bus.out_ready_i) begin
        out_valid_q <= 1'b0;
      end
      if (ptr_adv) ptr_q <= ptr_next;
    end
  end

  assign bus.in_ready_o  = ready;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = out_data_q;
  assign bus.out_sel_o   = out_sel_q;
  assign bus.out_last_o  = out_last_q;

endmodule
